// File: rtl/hv_encoder_seq_ctrl.sv
// Microcoded sequencer for the hypervector encoder: fetches one control word per
// cycle, runs a single hardware loop and stalls on the item-address stream.
module hv_encoder_seq_ctrl #(
  parameter int InstMemDepth = 64,
  parameter int ImAddrWidth  = 32,
  parameter int LoopCntWidth = 16,
  parameter int InstWidth    = 28,
  parameter int PcWidth      = $clog2(InstMemDepth)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,

  input  logic [PcWidth-1:0]      prog_end_i,
  input  logic [PcWidth-1:0]      loop_start_i,
  input  logic [PcWidth-1:0]      loop_end_i,
  input  logic [LoopCntWidth-1:0] loop_num_i,

  output logic [PcWidth-1:0]      inst_addr_o,
  input  logic [InstWidth-1:0]    inst_data_i,

  input  logic                    data_valid_i,
  output logic                    data_ready_o,
  input  logic [ImAddrWidth-1:0]  data_addr_a_i,
  input  logic [ImAddrWidth-1:0]  data_addr_b_i,
  output logic [ImAddrWidth-1:0]  im_a_addr_o,
  output logic [ImAddrWidth-1:0]  im_b_addr_o,

  output logic [1:0]              alu_mux_a_o,
  output logic [1:0]              alu_mux_b_o,
  output logic [1:0]              alu_ops_o,
  output logic [1:0]              bund_mux_a_o,
  output logic [1:0]              bund_mux_b_o,
  output logic                    bund_valid_a_o,
  output logic                    bund_valid_b_o,
  output logic                    bund_clr_a_o,
  output logic                    bund_clr_b_o,
  output logic [1:0]              reg_mux_o,
  output logic [1:0]              reg_rd_addr_a_o,
  output logic [1:0]              reg_rd_addr_b_o,
  output logic [1:0]              reg_wr_addr_o,
  output logic                    reg_wr_en_o,
  output logic                    qhv_clr_o,
  output logic                    qhv_wen_o,
  output logic [1:0]              qhv_mux_o
);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e                  state_q, state_d;
  logic [PcWidth-1:0]      pc_q, pc_d;
  logic [LoopCntWidth-1:0] loop_cnt_q, loop_cnt_d;
  logic [LoopCntWidth-1:0] loop_limit;
  logic                    done_q, done_d;
  logic                    running;
  logic                    need_data;
  logic                    exec;
  logic                    loop_back;

  assign running   = (state_q == RUN);
  assign need_data = inst_data_i[27];
  assign exec      = running && (!need_data || data_valid_i);

  // A loop count of zero behaves like one pass, so both give a limit of zero.
  assign loop_limit = (loop_num_i == '0) ? '0 : loop_num_i - LoopCntWidth'(1);
  assign loop_back  = (pc_q == loop_end_i) && (loop_cnt_q < loop_limit);

  assign inst_addr_o = pc_q;
  assign busy_o      = running;
  assign done_o      = done_q;
  assign im_a_addr_o = data_addr_a_i;
  assign im_b_addr_o = data_addr_b_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      loop_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      loop_cnt_q <= loop_cnt_d;
      done_q     <= done_d;
    end
  end

  // Loop-back is checked before program end so a loop closing on the last
  // instruction still runs all of its iterations.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    loop_cnt_d = loop_cnt_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = RUN;
          pc_d       = '0;
          loop_cnt_d = '0;
        end
      end
      RUN: begin
        if (exec) begin
          if (loop_back) begin
            pc_d       = loop_start_i;
            loop_cnt_d = loop_cnt_q + LoopCntWidth'(1);
          end else if (pc_q == prog_end_i) begin
            state_d    = IDLE;
            done_d     = 1'b1;
            loop_cnt_d = '0;
          end else begin
            pc_d = pc_q + PcWidth'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Selects follow the fetched word whenever running so the datapath can settle
  // during a stall; strobes only fire on an executing cycle.
  always_comb begin
    alu_mux_a_o     = '0;
    alu_mux_b_o     = '0;
    alu_ops_o       = '0;
    bund_mux_a_o    = '0;
    bund_mux_b_o    = '0;
    reg_mux_o       = '0;
    reg_rd_addr_a_o = '0;
    reg_rd_addr_b_o = '0;
    reg_wr_addr_o   = '0;
    qhv_mux_o       = '0;
    bund_valid_a_o  = 1'b0;
    bund_valid_b_o  = 1'b0;
    bund_clr_a_o    = 1'b0;
    bund_clr_b_o    = 1'b0;
    reg_wr_en_o     = 1'b0;
    qhv_clr_o       = 1'b0;
    qhv_wen_o       = 1'b0;
    data_ready_o    = 1'b0;
    if (running) begin
      alu_mux_a_o     = inst_data_i[1:0];
      alu_mux_b_o     = inst_data_i[3:2];
      alu_ops_o       = inst_data_i[5:4];
      bund_mux_a_o    = inst_data_i[7:6];
      bund_mux_b_o    = inst_data_i[9:8];
      reg_mux_o       = inst_data_i[15:14];
      reg_rd_addr_a_o = inst_data_i[17:16];
      reg_rd_addr_b_o = inst_data_i[19:18];
      reg_wr_addr_o   = inst_data_i[21:20];
      qhv_mux_o       = inst_data_i[26:25];
    end
    if (exec) begin
      bund_valid_a_o = inst_data_i[10];
      bund_valid_b_o = inst_data_i[11];
      bund_clr_a_o   = inst_data_i[12];
      bund_clr_b_o   = inst_data_i[13];
      reg_wr_en_o    = inst_data_i[22];
      qhv_clr_o      = inst_data_i[23];
      qhv_wen_o      = inst_data_i[24];
      data_ready_o   = need_data;
    end
  end

endmodule

// File: tb/tb_hv_encoder_seq_ctrl.sv
// Directed bench for hv_encoder_seq_ctrl: a trace-level model predicts the pc
// sequence from the loop configuration and is compared against the DUT each cycle.
module tb_hv_encoder_seq_ctrl;

  localparam int PcW = 6;
  localparam logic [26:0] StrobeMask = 27'h1C03C00;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             start_i = 1'b0;
  logic             busy_o, done_o;
  logic [PcW-1:0]   prog_end_i = '0, loop_start_i = '0, loop_end_i = '0;
  logic [15:0]      loop_num_i = 16'd1;
  logic [PcW-1:0]   inst_addr_o;
  logic [27:0]      inst_data_i;
  logic             data_valid_i = 1'b1;
  logic             data_ready_o;
  logic [31:0]      data_addr_a_i = 32'h0, data_addr_b_i = 32'h0;
  logic [31:0]      im_a_addr_o, im_b_addr_o;
  logic [1:0]       alu_mux_a_o, alu_mux_b_o, alu_ops_o, bund_mux_a_o, bund_mux_b_o;
  logic             bund_valid_a_o, bund_valid_b_o, bund_clr_a_o, bund_clr_b_o;
  logic [1:0]       reg_mux_o, reg_rd_addr_a_o, reg_rd_addr_b_o, reg_wr_addr_o;
  logic             reg_wr_en_o, qhv_clr_o, qhv_wen_o;
  logic [1:0]       qhv_mux_o;
  logic [26:0]      ctrl_bus;
  logic [27:0]      imem [64];

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  int trace[$];
  bit active = 0, pend_done = 0, start_seen = 0;
  int done_count = 0, ready_count = 0, busy_cycles = 0;

  always #5 clk_i = ~clk_i;

  assign inst_data_i = imem[inst_addr_o];
  assign ctrl_bus = {qhv_mux_o, qhv_wen_o, qhv_clr_o, reg_wr_en_o, reg_wr_addr_o,
                     reg_rd_addr_b_o, reg_rd_addr_a_o, reg_mux_o, bund_clr_b_o,
                     bund_clr_a_o, bund_valid_b_o, bund_valid_a_o, bund_mux_b_o,
                     bund_mux_a_o, alu_ops_o, alu_mux_b_o, alu_mux_a_o};

  hv_encoder_seq_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .prog_end_i(prog_end_i), .loop_start_i(loop_start_i), .loop_end_i(loop_end_i),
    .loop_num_i(loop_num_i), .inst_addr_o(inst_addr_o), .inst_data_i(inst_data_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
    .data_addr_a_i(data_addr_a_i), .data_addr_b_i(data_addr_b_i),
    .im_a_addr_o(im_a_addr_o), .im_b_addr_o(im_b_addr_o),
    .alu_mux_a_o(alu_mux_a_o), .alu_mux_b_o(alu_mux_b_o), .alu_ops_o(alu_ops_o),
    .bund_mux_a_o(bund_mux_a_o), .bund_mux_b_o(bund_mux_b_o),
    .bund_valid_a_o(bund_valid_a_o), .bund_valid_b_o(bund_valid_b_o),
    .bund_clr_a_o(bund_clr_a_o), .bund_clr_b_o(bund_clr_b_o),
    .reg_mux_o(reg_mux_o), .reg_rd_addr_a_o(reg_rd_addr_a_o),
    .reg_rd_addr_b_o(reg_rd_addr_b_o), .reg_wr_addr_o(reg_wr_addr_o),
    .reg_wr_en_o(reg_wr_en_o), .qhv_clr_o(qhv_clr_o), .qhv_wen_o(qhv_wen_o),
    .qhv_mux_o(qhv_mux_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected pc trace: prologue, the body repeated max(loop_num,1) times, epilogue.
  function automatic void buildExpected();
    int reps;
    exp_q.delete();
    reps = (loop_num_i == 16'd0) ? 1 : int'(loop_num_i);
    for (int p = 0; p < int'(loop_start_i); p++) exp_q.push_back(p);
    for (int r = 0; r < reps; r++)
      for (int p = int'(loop_start_i); p <= int'(loop_end_i); p++) exp_q.push_back(p);
    for (int p = int'(loop_end_i) + 1; p <= int'(prog_end_i); p++) exp_q.push_back(p);
  endfunction

  always @(negedge clk_i) begin
    logic [27:0] inst;
    bit stall;
    checkOutput("im_a_pass", im_a_addr_o, data_addr_a_i);
    checkOutput("im_b_pass", im_b_addr_o, data_addr_b_i);
    if (!rst_ni) begin
      active = 0; pend_done = 0; start_seen = 0;
      checkOutput("rst_busy", busy_o, 0);
      checkOutput("rst_done", done_o, 0);
      checkOutput("rst_ctrl", ctrl_bus, 0);
      checkOutput("rst_ready", data_ready_o, 0);
    end else begin
      if (start_seen) begin
        active = 1;
        buildExpected();
      end
      checkOutput("done", done_o, pend_done);
      if (done_o) done_count++;
      pend_done = 0;
      if (active) begin
        inst  = imem[exp_q[0]];
        stall = inst[27] && !data_valid_i;
        busy_cycles++;
        if (data_ready_o) ready_count++;
        checkOutput("busy", busy_o, 1);
        checkOutput("pc", inst_addr_o, exp_q[0]);
        checkOutput("ctrl", ctrl_bus, stall ? (inst[26:0] & ~StrobeMask) : inst[26:0]);
        checkOutput("ready", data_ready_o, inst[27] && data_valid_i);
        if (!stall) begin
          trace.push_back(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            active = 0;
            pend_done = 1;
          end
        end
      end else begin
        checkOutput("idle_busy", busy_o, 0);
        checkOutput("idle_ctrl", ctrl_bus, 0);
        checkOutput("idle_ready", data_ready_o, 0);
      end
      start_seen = start_i && !active && !pend_done;
    end
  end

  task automatic loadImem(input int need_pc);
    for (int i = 0; i < 64; i++) imem[i] = 28'($urandom) & 28'h7FF_FFFF;
    if (need_pc >= 0) imem[need_pc] = imem[need_pc] | 28'h840_0000;
  endtask

  task automatic compareTrace(input string name, input int ref_q[$]);
    checkOutput({name, "_len"}, trace.size(), ref_q.size());
    for (int i = 0; i < ref_q.size() && i < trace.size(); i++)
      checkOutput({name, "_pc"}, trace[i], ref_q[i]);
  endtask

  task automatic applyStimulus(input int pe, input int ls, input int le, input int ln,
                               input int stall_cycles, input bit extra_start);
    prog_end_i = PcW'(pe); loop_start_i = PcW'(ls);
    loop_end_i = PcW'(le); loop_num_i = 16'(ln);
    trace.delete(); done_count = 0; ready_count = 0; busy_cycles = 0;
    data_valid_i = (stall_cycles == 0);
    @(posedge clk_i); #2 start_i = 1'b1;
    @(posedge clk_i); #2 start_i = 1'b0;
    if (stall_cycles > 0) begin
      repeat (stall_cycles) @(posedge clk_i);
      #2 data_valid_i = 1'b1;
      data_addr_a_i = 32'hA5A5_0001; data_addr_b_i = 32'h5A5A_0002;
    end
    if (extra_start) begin
      repeat (2) @(posedge clk_i);
      #2 start_i = 1'b1;
      @(posedge clk_i); #2 start_i = 1'b0;
    end
    for (int i = 0; i < 300 && done_count == 0; i++) @(posedge clk_i);
    repeat (3) @(posedge clk_i);
    #2;
    checkOutput("done_count", done_count, 1);
  endtask

  initial begin
    int seq[$];
    loadImem(-1);
    repeat (3) @(posedge clk_i);
    #2;
    checkOutput("rst_pc", inst_addr_o, 0);
    rst_ni = 1'b1;
    @(posedge clk_i); #2;

    $display("[TB] plain program, prog_end=3");
    applyStimulus(3, 0, 0, 1, 0, 0);
    seq = '{0, 1, 2, 3};
    compareTrace("plain", seq);
    checkOutput("plain_cycles", busy_cycles, 4);

    $display("[TB] stall on instruction 0 for three cycles");
    loadImem(0);
    applyStimulus(3, 0, 0, 1, 3, 0);
    compareTrace("stall", seq);
    checkOutput("stall_cycles", busy_cycles, 7);
    checkOutput("stall_beats", ready_count, 1);

    $display("[TB] loop 1..2 x3, prog_end=3");
    loadImem(2);
    applyStimulus(3, 1, 2, 3, 0, 0);
    seq = '{0, 1, 2, 1, 2, 1, 2, 3};
    compareTrace("loop3", seq);
    checkOutput("loop3_beats", ready_count, 3);

    $display("[TB] loop_num=0 behaves as one pass");
    applyStimulus(3, 1, 2, 0, 0, 0);
    seq = '{0, 1, 2, 3};
    compareTrace("loop0", seq);
    checkOutput("loop0_beats", ready_count, 1);

    $display("[TB] loop_end equals prog_end");
    loadImem(-1);
    applyStimulus(2, 1, 2, 2, 0, 0);
    seq = '{0, 1, 2, 1, 2};
    compareTrace("loopend", seq);

    $display("[TB] start while busy is ignored");
    applyStimulus(5, 0, 0, 1, 0, 1);
    seq = '{0, 1, 2, 3, 4, 5};
    compareTrace("restart", seq);

    $display("[TB] reset in the middle of a program");
    prog_end_i = PcW'(10); loop_start_i = '0; loop_end_i = '0; loop_num_i = 16'd1;
    done_count = 0;
    @(posedge clk_i); #2 start_i = 1'b1;
    @(posedge clk_i); #2 start_i = 1'b0;
    for (int i = 0; i < 40 && inst_addr_o != PcW'(5); i++) begin
      @(posedge clk_i); #2;
    end
    checkOutput("mid_pc_reached", inst_addr_o, 5);
    rst_ni = 1'b0;
    #1;
    checkOutput("mid_busy", busy_o, 0);
    checkOutput("mid_pc", inst_addr_o, 0);
    checkOutput("mid_ctrl", ctrl_bus, 0);
    checkOutput("mid_done", done_o, 0);
    @(posedge clk_i); #2 rst_ni = 1'b1;
    repeat (4) @(posedge clk_i);
    #2;
    checkOutput("mid_no_done", done_count, 0);
    checkOutput("mid_idle", busy_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
